// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory arbiter: FSM states and owner encodings.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: on conflict, the master that was not served last wins.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_owner,
  output logic       o_gnt_valid_c,
  output logic       o_gnt_idx_c
);
  import mem_arb_pkg::*;

  always_comb begin
    o_gnt_valid_c = |i_req;
    o_gnt_idx_c   = M0;
    if (i_req == 2'b11) begin
      o_gnt_idx_c = ~i_last_owner;
    end else if (i_req[1]) begin
      o_gnt_idx_c = M1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master single-port memory arbiter/sequencer: serialises accesses, drives the memory
// for MEM_LAT cycles, returns read data and pulses a one-cycle ack to the served master.
module mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);
  import mem_arb_pkg::*;

  localparam int unsigned CW = $clog2(MEM_LAT + 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_last_owner;
  logic          r_owner;
  logic          r_we;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_m0_rdata;
  logic [DW-1:0] r_m1_rdata;
  logic          r_m0_ack;
  logic          r_m1_ack;
  logic          r_busy;

  logic          w_gnt_valid;
  logic          w_gnt_idx;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  rr_arb2 u_rr_arb2 (
    .i_req         ({m1_req, m0_req}),
    .i_last_owner  (r_last_owner),
    .o_gnt_valid_c (w_gnt_valid),
    .o_gnt_idx_c   (w_gnt_idx)
  );

  assign w_sel_we    = (w_gnt_idx == M1) ? m1_we    : m0_we;
  assign w_sel_addr  = (w_gnt_idx == M1) ? m1_addr  : m0_addr;
  assign w_sel_wdata = (w_gnt_idx == M1) ? m1_wdata : m0_wdata;

  // Sequencer: IDLE samples requests, ACCESS holds the latched command for MEM_LAT cycles, DONE acks.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last_owner <= M1;
      r_owner      <= M0;
      r_we         <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_owner     <= w_gnt_idx;
            r_we        <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_sel_we;
            r_cnt       <= CW'(1);
            r_busy      <= 1'b1;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          // Write strobe is only asserted on the first access cycle.
          r_mem_we <= 1'b0;
          if (r_cnt == CW'(MEM_LAT)) begin
            r_mem_en <= 1'b0;
            r_state  <= DONE;
            if (r_owner == M0) begin
              r_m0_ack <= 1'b1;
              if (!r_we) r_m0_rdata <= mem_rdata;
            end else begin
              r_m1_ack <= 1'b1;
              if (!r_we) r_m1_rdata <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          r_last_owner <= r_owner;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;
  assign m0_ack    = r_m0_ack;
  assign m1_ack    = r_m1_ack;
  assign busy      = r_busy;
  assign owner     = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: master drivers push expected transactions, a negedge monitor
// pops them on every ack and checks data, latency, memory-side activity and grant order.
module tb_mem_arbiter;

  localparam int unsigned LAT = 2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_i   [2];
  logic        we_i    [2];
  logic [31:0] addr_i  [2];
  logic [31:0] wdata_i [2];
  logic [31:0] rd      [2];
  logic        m0_ack, m1_ack;
  logic [1:0]  acks;
  logic        mem_en, mem_we, busy, owner;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  exp_t        exp_q [2][$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] last_rd [2];
  int          en_cnt  [2];
  int          we_cnt  [2];
  int          run_len = 0;
  int          log_m [$];
  int          log_c [$];
  event        m0_first;

  assign acks = {m1_ack, m0_ack};

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
    .clock     (clock),
    .reset     (reset),
    .m0_req    (req_i[0]),
    .m0_we     (we_i[0]),
    .m0_addr   (addr_i[0]),
    .m0_wdata  (wdata_i[0]),
    .m0_rdata  (rd[0]),
    .m0_ack    (m0_ack),
    .m1_req    (req_i[1]),
    .m1_we     (we_i[1]),
    .m1_addr   (addr_i[1]),
    .m1_wdata  (wdata_i[1]),
    .m1_rdata  (rd[1]),
    .m1_ack    (m1_ack),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .owner     (owner)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory device: data is valid only in the LAT-th consecutive enabled cycle, junk otherwise.
  always @(negedge clock) begin
    if (mem_en) run_len++;
    else run_len = 0;
    if (mem_en && mem_we) dev_mem[mem_addr] = mem_wdata;
    mem_rdata = (mem_en && run_len == LAT) ? dev_rd(mem_addr) : $urandom();
  end

  // Monitor: memory-side checks against the in-flight transaction, scoreboard pop on ack.
  always @(negedge clock) begin
    exp_t c;
    exp_t e;
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        en_cnt[m]  = 0;
        we_cnt[m]  = 0;
        last_rd[m] = '0;
      end
    end else begin
      if (mem_en) begin
        en_cnt[owner]++;
        if (exp_q[owner].size() > 0) begin
          c = exp_q[owner][0];
          chk("mem_addr", mem_addr, c.addr);
          if (mem_we) begin
            we_cnt[owner]++;
            chk("mem_we_on_write", 32'(c.we), 32'(1));
            chk("mem_wdata", mem_wdata, c.wdata);
          end
        end
      end
      if (m0_ack && m1_ack) begin
        checks++;
        errors++;
        $display("FAIL dual_ack: both acks high, required at most one (cycle %0d)", cyc);
      end
      for (int m = 0; m < 2; m++) begin
        if (acks[m]) begin
          if (exp_q[m].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_ack m%0d: got ack, required none (cycle %0d)", m, cyc);
          end else begin
            e = exp_q[m].pop_front();
            if (!e.we) last_rd[m] = e.rdata;
            chk($sformatf("m%0d_rdata", m), rd[m], last_rd[m]);
            chk($sformatf("m%0d_mem_en_cycles", m), 32'(en_cnt[m]), 32'(LAT));
            chk($sformatf("m%0d_mem_we_pulses", m), 32'(we_cnt[m]), e.we ? 32'(1) : 32'(0));
            chk($sformatf("m%0d_ack_owner", m), 32'(owner), 32'(m));
            chk($sformatf("m%0d_ack_busy", m), 32'(busy), 32'(1));
            chk($sformatf("m%0d_ack_mem_en", m), 32'(mem_en), 32'(0));
            if (e.ack_cyc >= 0) chk($sformatf("m%0d_ack_cycle", m), 32'(cyc), 32'(e.ack_cyc));
            log_m.push_back(m);
            log_c.push_back(cyc);
          end
          en_cnt[m] = 0;
          we_cnt[m] = 0;
        end
      end
    end
  end

  // Present one transaction, hold it until ack; req stays high on return.
  task automatic issue(input int m, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input bit lone, input bit scramble);
    exp_t e;
    bit   got;
    @(posedge clock);
    #1;
    req_i[m]   = 1'b1;
    we_i[m]    = w;
    addr_i[m]  = a;
    wdata_i[m] = d;
    e.we      = w;
    e.addr    = a;
    e.wdata   = d;
    e.rdata   = w ? 32'h0 : ref_rd(a);
    e.ack_cyc = lone ? cyc + int'(LAT) + 1 : -1;
    if (w) ref_mem[a] = d;
    exp_q[m].push_back(e);
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clock);
      #1;
      if (scramble && i == 0) begin
        addr_i[m]  = ~a;
        wdata_i[m] = ~d;
        we_i[m]    = ~w;
      end
      if (acks[m]) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL m%0d_ack_timeout: no ack within 60 cycles for addr %0h", m, a);
      req_i[m] = 1'b0;
      exp_q[m].delete();
    end
  endtask

  task automatic idle(input int m);
    @(posedge clock);
    #1;
    req_i[m] = 1'b0;
  endtask

  task automatic pulse_reset();
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic rand_master(input int m, input int n);
    logic [31:0] a;
    int          gap;
    for (int i = 0; i < n; i++) begin
      a = ((m == 0) ? 32'h100 : 32'h40) + 32'(4 * $urandom_range(0, 15));
      issue(m, 1'($urandom_range(0, 1)), a, $urandom(), 1'b0, 1'b0);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        idle(m);
        repeat (gap - 1) @(posedge clock);
      end
    end
    idle(m);
  endtask

  initial begin
    int s;
    int fair_exp [4] = '{0, 1, 0, 1};
    int pri_exp  [3] = '{0, 1, 0};
    reset = 1'b1;
    for (int m = 0; m < 2; m++) begin
      req_i[m] = 1'b0; we_i[m] = 1'b0; addr_i[m] = '0; wdata_i[m] = '0;
    end
    mem_rdata = '0;
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    dev_mem[32'h100] = 32'hDEAD_BEEF;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_mem_en", 32'(mem_en), 32'(0));
    chk("rst_mem_we", 32'(mem_we), 32'(0));
    chk("rst_acks", 32'(acks), 32'(0));
    chk("rst_owner", 32'(owner), 32'(0));
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_m0_rdata", rd[0], 32'h0);
    chk("rst_m1_rdata", rd[1], 32'h0);
    reset = 1'b0;

    // Directed read then write.
    issue(0, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0);
    idle(0);
    chk("m0_rdata_deadbeef", rd[0], 32'hDEAD_BEEF);
    issue(1, 1'b1, 32'h40, 32'h1234_5678, 1'b1, 1'b0);
    idle(1);
    chk("m1_rdata_after_write", rd[1], 32'h0);
    chk("mem_0x40_written", dev_rd(32'h40), 32'h1234_5678);

    // Continuous conflict after reset: strict alternation at LAT+2 spacing.
    pulse_reset();
    s = log_m.size();
    fork
      begin
        issue(0, 1'b0, 32'h104, 32'h0, 1'b0, 1'b0);
        issue(0, 1'b1, 32'h108, 32'hA5A5_1111, 1'b0, 1'b0);
        idle(0);
      end
      begin
        issue(1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0);
        issue(1, 1'b1, 32'h48, 32'h5A5A_2222, 1'b0, 1'b0);
        idle(1);
      end
    join
    chk("fair_n_acks", 32'(log_m.size() - s), 32'(4));
    if (log_m.size() - s == 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("fair_owner_%0d", i), 32'(log_m[s+i]), 32'(fair_exp[i]));
      for (int i = 1; i < 4; i++) chk($sformatf("fair_gap_%0d", i), 32'(log_c[s+i] - log_c[s+i-1]), 32'(LAT + 2));
    end

    // Lone master back-to-back; second transaction has its fields scrambled during ACCESS.
    for (int i = 0; i < 4; i++)
      issue(0, 1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 15)), $urandom(), 1'b1, i == 1);
    idle(0);

    // Simultaneous requests right after an m0 access: m1 goes first.
    s = log_m.size();
    fork
      begin
        issue(0, 1'b0, 32'h10C, 32'h0, 1'b1, 1'b0);
        -> m0_first;
        issue(0, 1'b0, 32'h110, 32'h0, 1'b0, 1'b0);
        idle(0);
      end
      begin
        @(m0_first);
        issue(1, 1'b0, 32'h4C, 32'h0, 1'b0, 1'b0);
        idle(1);
      end
    join
    chk("prio_n_acks", 32'(log_m.size() - s), 32'(3));
    if (log_m.size() - s == 3)
      for (int i = 0; i < 3; i++) chk($sformatf("prio_owner_%0d", i), 32'(log_m[s+i]), 32'(pri_exp[i]));

    // Reset in the second ACCESS cycle of an m1 read: access dropped, no ack.
    @(posedge clock);
    #1;
    req_i[1] = 1'b1; we_i[1] = 1'b0; addr_i[1] = 32'h50;
    @(posedge clock);
    #1;
    chk("midrst_owner_before", 32'(owner), 32'(1));
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    req_i[1] = 1'b0;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_mem_en", 32'(mem_en), 32'(0));
    chk("midrst_acks", 32'(acks), 32'(0));
    chk("midrst_owner", 32'(owner), 32'(0));
    repeat (3) @(posedge clock);
    issue(1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b0);
    idle(1);

    // Randomized contention between both masters.
    fork
      rand_master(0, 10);
      rand_master(1, 10);
    join
    repeat (5) @(posedge clock);
    chk("m0_queue_drained", 32'(exp_q[0].size()), 32'(0));
    chk("m1_queue_drained", 32'(exp_q[1].size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
